shiftadd_mult_param: RTL

//   Parametrised sequential shift-and-add multiplier with start/busy/done handshake.

---
 rtl/shiftadd_mult_param.sv | 104 ++++++++++
 1 files changed

// File: rtl/shiftadd_mult_param.sv
// Sequential shift-and-add multiplier, one multiplier bit per clock, with
// unsigned or two's-complement operation selected per request.
module shiftadd_mult_param #(
  parameter int W = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           signed_mode,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*W-1:0] mul
);

  localparam int CW = (W > 2) ? $clog2(W) : 1;
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX
  } state_t;

  state_t         state, state_n;
  logic [2*W-1:0] acc, acc_n, mul_n;
  logic [W-1:0]   mcand, mcand_n, mplier, mplier_n;
  logic [CW-1:0]  count, count_n;
  logic           neg, neg_n, busy_n, done_n;
  logic [W-1:0]   mag_a, mag_b;

  // Signed operands are reduced to magnitudes; -2^(W-1) maps to 2^(W-1),
  // which still fits in W unsigned bits.
  always_comb begin
    mag_a = a;
    mag_b = b;
    if (signed_mode && a[W-1]) mag_a = ~a + 1'b1;
    if (signed_mode && b[W-1]) mag_b = ~b + 1'b1;
  end

  always_comb begin
    state_n  = state;
    acc_n    = acc;
    mcand_n  = mcand;
    mplier_n = mplier;
    count_n  = count;
    neg_n    = neg;
    busy_n   = busy;
    done_n   = 1'b0;
    mul_n    = mul;
    case (state)
      IDLE: begin
        if (start) begin
          state_n  = CALC;
          count_n  = '0;
          acc_n    = '0;
          mcand_n  = mag_a;
          mplier_n = mag_b;
          neg_n    = signed_mode & (a[W-1] ^ b[W-1]);
          busy_n   = 1'b1;
        end
      end
      CALC: begin
        if (mplier[0]) acc_n = acc + ({{W{1'b0}}, mcand} << count);
        mplier_n = mplier >> 1;
        count_n  = count + 1'b1;
        if (count == LAST) state_n = FIX;
      end
      FIX: begin
        mul_n   = neg ? (~acc + 1'b1) : acc;
        done_n  = 1'b1;
        busy_n  = 1'b0;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      mul    <= '0;
      count  <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      neg    <= 1'b0;
    end else begin
      state  <= state_n;
      busy   <= busy_n;
      done   <= done_n;
      mul    <= mul_n;
      count  <= count_n;
      acc    <= acc_n;
      mcand  <= mcand_n;
      mplier <= mplier_n;
      neg    <= neg_n;
    end
  end

endmodule
